// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor: PHT of 2-bit saturating counters indexed by PC.
// Optional performance counters are enabled with BRANCH_PRED_STATS_EN.
module branch_predictor #(
    parameter int unsigned IDX_W   = 4,
    parameter logic [1:0]  CNT_RST = 2'b01
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        fetch_valid_in,
    input  logic [31:0] fetch_pc_in,
    output logic        pred_valid_out,
    output logic        pred_taken_out,
    input  logic        resolve_valid_in,
    input  logic        resolve_cond_in,
    input  logic [31:0] resolve_pc_in,
    input  logic        resolve_taken_in,
    input  logic        resolve_pred_in,
`ifdef BRANCH_PRED_STATS_EN
    input  logic        stat_clr_in,
    output logic [31:0] stat_branches_out,
    output logic [31:0] stat_mispred_out,
`endif
    output logic        mispredict_out
);

    localparam int unsigned Entries = 2 ** IDX_W;

    logic [1:0]       pht_q [Entries];
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] resolve_idx;
    logic             upd_en;
    logic [1:0]       cnt_cur;
    logic [1:0]       cnt_nxt;
    logic             pred_valid_d, pred_valid_q;
    logic             pred_taken_d, pred_taken_q;
    logic             mispredict_d, mispredict_q;

    assign fetch_idx   = fetch_pc_in[IDX_W+1:2];
    assign resolve_idx = resolve_pc_in[IDX_W+1:2];
    assign upd_en      = resolve_valid_in & resolve_cond_in;
    assign cnt_cur     = pht_q[resolve_idx];

    always_comb begin
        cnt_nxt = cnt_cur;
        if (resolve_taken_in) begin
            if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'b01;
        end else begin
            if (cnt_cur != 2'b00) cnt_nxt = cnt_cur - 2'b01;
        end
    end

    // Read uses the registered table, so a same-cycle update is not bypassed.
    always_comb begin
        pred_valid_d = fetch_valid_in;
        pred_taken_d = fetch_valid_in ? pht_q[fetch_idx][1] : pred_taken_q;
        mispredict_d = resolve_valid_in & (resolve_taken_in != resolve_pred_in);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < Entries; i++) begin
                pht_q[i] <= CNT_RST;
            end
        end else if (upd_en) begin
            pht_q[resolve_idx] <= cnt_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign pred_valid_out = pred_valid_q;
    assign pred_taken_out = pred_taken_q;
    assign mispredict_out = mispredict_q;

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] branches_d, branches_q;
    logic [31:0] mispred_d, mispred_q;

    always_comb begin
        branches_d = branches_q;
        mispred_d  = mispred_q;
        if (stat_clr_in) begin
            branches_d = '0;
            mispred_d  = '0;
        end else begin
            if (upd_en) branches_d = branches_q + 32'd1;
            if (upd_en && mispredict_d) mispred_d = mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            branches_q <= branches_d;
            mispred_q  <= mispred_d;
        end
    end

    assign stat_branches_out = branches_q;
    assign stat_mispred_out  = mispred_q;
`endif

    // PC bits outside the index field do not participate.
    logic unused_pc;
    assign unused_pc = ^{fetch_pc_in[31:IDX_W+2], fetch_pc_in[1:0],
                         resolve_pc_in[31:IDX_W+2], resolve_pc_in[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, random traffic
// against a counter-array model, and an asynchronous mid-run reset.
module tb_branch_predictor;

    localparam int unsigned IdxW    = 4;
    localparam int unsigned Entries = 16;

    logic        clk;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic        resolve_valid;
    logic        resolve_cond;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic        resolve_pred;
    logic        mispredict;
    logic        stat_clr;
`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    branch_predictor #(
        .IDX_W   (IdxW),
        .CNT_RST (2'b01)
    ) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .fetch_valid_in    (fetch_valid),
        .fetch_pc_in       (fetch_pc),
        .pred_valid_out    (pred_valid),
        .pred_taken_out    (pred_taken),
        .resolve_valid_in  (resolve_valid),
        .resolve_cond_in   (resolve_cond),
        .resolve_pc_in     (resolve_pc),
        .resolve_taken_in  (resolve_taken),
        .resolve_pred_in   (resolve_pred),
`ifdef BRANCH_PRED_STATS_EN
        .stat_clr_in       (stat_clr),
        .stat_branches_out (stat_branches),
        .stat_mispred_out  (stat_mispred),
`endif
        .mispredict_out    (mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: counter values 0..3 per table entry.
    int          cnt [Entries];
    logic        exp_pv, exp_pt, exp_mis;
    int unsigned exp_br, exp_mp;

    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        rv;
        logic        rc;
        logic [31:0] rpc;
        logic        rt;
        logic        rp;
        logic        pv;
        logic        pt;
        logic        mis;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mk(input logic fv, input logic [31:0] fpc, input logic rv,
                                input logic rc, input logic [31:0] rpc, input logic rt,
                                input logic rp, input logic pv, input logic pt,
                                input logic mis);
        vec_t v;
        v.fv = fv; v.fpc = fpc; v.rv = rv; v.rc = rc; v.rpc = rpc;
        v.rt = rt; v.rp = rp; v.pv = pv; v.pt = pt; v.mis = mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < Entries; i++) cnt[i] = 1;
        exp_pv = 1'b0; exp_pt = 1'b0; exp_mis = 1'b0;
        exp_br = 0; exp_mp = 0;
    endtask

    // Called at a negedge: drive, advance model, wait one cycle, return at next negedge.
    task automatic step(input logic fv, input logic [31:0] fpc, input logic rv,
                        input logic rc, input logic [31:0] rpc, input logic rt,
                        input logic rp, input logic clr);
        int fi, ri;
        fetch_valid = fv; fetch_pc = fpc;
        resolve_valid = rv; resolve_cond = rc; resolve_pc = rpc;
        resolve_taken = rt; resolve_pred = rp; stat_clr = clr;
        fi = int'((fpc >> 2) % Entries);
        ri = int'((rpc >> 2) % Entries);
        exp_pv = fv;
        if (fv) exp_pt = (cnt[fi] >= 2);
        exp_mis = rv && (rt != rp);
        if (clr) begin
            exp_br = 0; exp_mp = 0;
        end else if (rv && rc) begin
            exp_br++;
            if (rt != rp) exp_mp++;
        end
        if (rv && rc) cnt[ri] = rt ? ((cnt[ri] < 3) ? cnt[ri] + 1 : 3)
                                   : ((cnt[ri] > 0) ? cnt[ri] - 1 : 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_stats(input string tag);
`ifdef BRANCH_PRED_STATS_EN
        check({tag, "_stat_branches"}, stat_branches, exp_br);
        check({tag, "_stat_mispred"}, stat_mispred, exp_mp);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_valid = 0; fetch_pc = 0; resolve_valid = 0; resolve_cond = 0;
        resolve_pc = 0; resolve_taken = 0; resolve_pred = 0; stat_clr = 0;
        model_reset();

        repeat (2) @(negedge clk);
        check("reset_pred_valid", {31'b0, pred_valid}, 32'd0);
        check("reset_pred_taken", {31'b0, pred_taken}, 32'd0);
        check("reset_mispredict", {31'b0, mispredict}, 32'd0);
        check_stats("reset");
        rst_n = 1'b1;

        // Directed table; all of 0x40, 0x80, 0x440 share index 0.
        vecs[0]  = mk(1, 32'h40,  0, 0, 32'h0,  0, 0, 1, 0, 0);
        vecs[1]  = mk(0, 32'h0,   1, 1, 32'h40, 1, 1, 0, 0, 0);
        vecs[2]  = mk(0, 32'h0,   1, 1, 32'h40, 1, 1, 0, 0, 0);
        vecs[3]  = mk(0, 32'h0,   1, 1, 32'h40, 1, 1, 0, 0, 0);
        vecs[4]  = mk(0, 32'h0,   1, 1, 32'h40, 1, 1, 0, 0, 0);
        vecs[5]  = mk(1, 32'h40,  0, 0, 32'h0,  0, 0, 1, 1, 0);
        vecs[6]  = mk(1, 32'h40,  1, 1, 32'h40, 0, 1, 1, 1, 1);
        vecs[7]  = mk(1, 32'h40,  1, 1, 32'h40, 0, 1, 1, 1, 1);
        vecs[8]  = mk(1, 32'h40,  1, 1, 32'h40, 0, 1, 1, 0, 1);
        vecs[9]  = mk(1, 32'h40,  1, 1, 32'h40, 0, 1, 1, 0, 1);
        vecs[10] = mk(1, 32'h40,  0, 0, 32'h0,  0, 0, 1, 0, 0);
        vecs[11] = mk(0, 32'h0,   1, 1, 32'h80, 1, 0, 0, 0, 1);
        vecs[12] = mk(0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 0, 0);
        vecs[13] = mk(0, 32'h0,   1, 1, 32'h80, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 32'h0,   1, 1, 32'h80, 1, 1, 0, 0, 0);
        vecs[15] = mk(1, 32'h40,  1, 1, 32'h40, 1, 0, 1, 0, 1);
        vecs[16] = mk(1, 32'h40,  0, 0, 32'h0,  0, 0, 1, 1, 0);
        vecs[17] = mk(1, 32'h440, 0, 0, 32'h0,  0, 0, 1, 1, 0);
        vecs[18] = mk(0, 32'h0,   1, 1, 32'h40, 0, 1, 0, 1, 1);
        vecs[19] = mk(0, 32'h0,   1, 0, 32'h40, 1, 0, 0, 1, 1);
        vecs[20] = mk(1, 32'h40,  0, 0, 32'h0,  0, 0, 1, 0, 0);
        vecs[21] = mk(1, 32'h44,  0, 0, 32'h0,  0, 0, 1, 0, 0);

        @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            step(vecs[i].fv, vecs[i].fpc, vecs[i].rv, vecs[i].rc, vecs[i].rpc,
                 vecs[i].rt, vecs[i].rp, 1'b0);
            check($sformatf("vec%0d_pred_valid", i), {31'b0, pred_valid}, {31'b0, vecs[i].pv});
            check($sformatf("vec%0d_pred_taken", i), {31'b0, pred_taken}, {31'b0, vecs[i].pt});
            check($sformatf("vec%0d_mispredict", i), {31'b0, mispredict}, {31'b0, vecs[i].mis});
            check_stats($sformatf("vec%0d", i));
        end

        // Random traffic; upper and low PC bits are randomised to exercise aliasing.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
            check("rnd_pred_valid", {31'b0, pred_valid}, {31'b0, exp_pv});
            check("rnd_pred_taken", {31'b0, pred_taken}, {31'b0, exp_pt});
            check("rnd_mispredict", {31'b0, mispredict}, {31'b0, exp_mis});
            check_stats("rnd");
        end

        // Get all outputs high, then reset asynchronously mid-cycle.
        repeat (3) step(0, 0, 1, 1, 32'h0, 1, 1, 0);
        step(1, 32'h0, 1, 1, 32'h0, 1, 0, 0);
        check("pre_rst_pred_valid", {31'b0, pred_valid}, 32'd1);
        check("pre_rst_pred_taken", {31'b0, pred_taken}, 32'd1);
        check("pre_rst_mispredict", {31'b0, mispredict}, 32'd1);
        fetch_valid = 0; resolve_valid = 0; stat_clr = 0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pred_valid", {31'b0, pred_valid}, 32'd0);
        check("async_rst_pred_taken", {31'b0, pred_taken}, 32'd0);
        check("async_rst_mispredict", {31'b0, mispredict}, 32'd0);
        model_reset();
        check_stats("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Every counter must be back at weakly not-taken: predicts 0, one taken flips it.
        for (int i = 0; i < Entries; i++) begin
            step(1, 32'(i * 4), 1, 1, 32'(i * 4), 1, 1, 0);
            check($sformatf("post_rst_idx%0d_first", i), {31'b0, pred_taken}, 32'd0);
            step(1, 32'(i * 4), 0, 0, 32'h0, 0, 0, 0);
            check($sformatf("post_rst_idx%0d_second", i), {31'b0, pred_taken}, 32'd1);
        end
        check_stats("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
